// File: rtl/ip_tuple_parse_q_pkg.sv
// Shared types and flit layout constants for the IP 4-tuple parser.
// Header and metadata fields sit MSB-aligned in the flit; the offsets below
// are measured from the flit MSB and match the packed struct layouts.
package ip_tuple_parse_q_pkg;

  localparam int NOC_DATA_W   = 256;
  localparam int MSG_LEN_W    = 16;
  localparam int META_FLITS_W = 8;
  localparam int PORT_NUM_W   = 16;
  localparam int IP_ADDR_W    = 32;

  localparam logic [MSG_LEN_W-1:0] MSG_LEN_ZERO = MSG_LEN_W'(0);
  localparam logic [MSG_LEN_W-1:0] MSG_LEN_ONE  = MSG_LEN_W'(1);

  // Load-balancer hash key.
  typedef struct packed {
    logic [IP_ADDR_W-1:0]  src_ip;
    logic [IP_ADDR_W-1:0]  dst_ip;
    logic [PORT_NUM_W-1:0] src_port;
    logic [PORT_NUM_W-1:0] dst_port;
  } hash_struct;

  // Tuple queue entry: key plus a flag telling whether the ports are real.
  typedef struct packed {
    hash_struct tuple;
    logic       has_ports;
  } ip_tuple_q_entry;

  // NoC header flit (MSB-aligned).
  typedef struct packed {
    logic [7:0]              dst_x;
    logic [7:0]              dst_y;
    logic [7:0]              dst_fbits;
    logic [MSG_LEN_W-1:0]    msg_len;
    logic [7:0]              msg_type;
    logic [7:0]              src_x;
    logic [7:0]              src_y;
    logic [7:0]              src_fbits;
    logic [META_FLITS_W-1:0] metadata_flits;
  } noc_hdr_flit;

  // IP receive metadata flit (MSB-aligned).
  typedef struct packed {
    logic [IP_ADDR_W-1:0] src_ip;
    logic [IP_ADDR_W-1:0] dst_ip;
    logic [15:0]          data_payload_len;
    logic [7:0]           protocol;
  } ip_rx_metadata_flit;

  // Bit offsets from the flit MSB of the fields the parser reads.
  localparam int HDR_MSG_LEN_OFF    = 24;
  localparam int HDR_META_FLITS_OFF = 72;
  localparam int META_SRC_IP_OFF    = 0;
  localparam int META_DST_IP_OFF    = 32;

  // Assemble a queue entry from its parts.
  function automatic ip_tuple_q_entry make_entry(
    input logic [IP_ADDR_W-1:0]  src_ip,
    input logic [IP_ADDR_W-1:0]  dst_ip,
    input logic [PORT_NUM_W-1:0] src_port,
    input logic [PORT_NUM_W-1:0] dst_port,
    input logic                  has_ports
  );
    ip_tuple_q_entry e;
    e.tuple.src_ip   = src_ip;
    e.tuple.dst_ip   = dst_ip;
    e.tuple.src_port = src_port;
    e.tuple.dst_port = dst_port;
    e.has_ports      = has_ports;
    return e;
  endfunction

endpackage

// File: rtl/ip_tuple_parse_q_chk.sv
// Simulation-only checks on the parser: zero-length headers are illegal and
// the tuple queue must never report more entries than it has.
module ip_tuple_parse_q_chk
  import ip_tuple_parse_q_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     hdr_xfer,
  input logic [MSG_LEN_W-1:0]     hdr_msg_len,
  input logic [$clog2(DEPTH):0]   occ
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  // Flag illegal header lengths and queue overfill on every active edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (hdr_xfer) begin
        assert (hdr_msg_len != MSG_LEN_ZERO)
          else $error("ip_tuple_parse_q: header with msg_len 0");
      end
      assert (occ <= OCC_W'(DEPTH))
        else $error("ip_tuple_parse_q: tuple queue occupancy above depth");
    end
  end

endmodule

// File: rtl/ip_tuple_parse_q_fifo.sv
// First-word-fall-through queue holding parsed tuples.
// A write while full is accepted only when a read retires the head in the
// same cycle, so occupancy never exceeds DEPTH.
module ip_tuple_parse_q_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_val,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     rd_val,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     rd_rdy,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (occ_q == OCC_FULL);
  assign rd_val  = (occ_q != OCC_ZERO);
  assign rd_data = mem_q[rd_ptr_q];
  assign occ     = occ_q;
  assign do_rd_s = rd_val & rd_rdy;
  assign do_wr_s = wr_val & (~full | do_rd_s);

  // Next storage, pointers and occupancy from the write/read strobes.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_wr_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_wr_s, do_rd_s})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Queue state registers; everything clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/ip_tuple_parse_q.sv
// Pass-through parser for IP NoC messages. Flits flow straight through with
// zero latency; one {src_ip, dst_ip, src_port, dst_port} tuple per message is
// pushed into a small queue. Data is only held back when the push flit meets
// a full queue that is not draining in the same cycle.
module ip_tuple_parse_q
  import ip_tuple_parse_q_pkg::*;
#(
  parameter int DATA_W        = NOC_DATA_W,
  parameter int PORT_OFFSET   = 0,
  parameter int IP_META_IDX   = 0,
  parameter int TUPLE_Q_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            src_val,
  input  logic [DATA_W-1:0]               src_data,
  output logic                            src_rdy,
  output logic                            dst_val,
  output logic [DATA_W-1:0]               dst_data,
  output logic                            dst_last,
  input  logic                            dst_rdy,
  output logic                            tuple_val,
  output hash_struct                      tuple,
  output logic                            tuple_has_ports,
  input  logic                            tuple_rdy,
  output logic [$clog2(TUPLE_Q_DEPTH):0]  tuple_q_occ
);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    META = 2'd1,
    PAY  = 2'd2,
    BODY = 2'd3
  } parse_state_e;

  localparam int ENTRY_W       = $bits(ip_tuple_q_entry);
  localparam int PORT_SRC_MSB  = DATA_W - 1 - PORT_OFFSET;
  localparam int PORT_DST_MSB  = PORT_SRC_MSB - PORT_NUM_W;
  localparam logic [MSG_LEN_W-1:0] IP_META_IDX_L = MSG_LEN_W'(IP_META_IDX);

  parse_state_e          state_q, state_d;
  logic [MSG_LEN_W-1:0]  rem_q, rem_d;
  logic [MSG_LEN_W-1:0]  meta_cnt_q, meta_cnt_d;
  logic [MSG_LEN_W-1:0]  meta_flits_q, meta_flits_d;
  logic [IP_ADDR_W-1:0]  staged_src_ip_q, staged_src_ip_d;
  logic [IP_ADDR_W-1:0]  staged_dst_ip_q, staged_dst_ip_d;

  logic [MSG_LEN_W-1:0]  hdr_msg_len_s;
  logic [MSG_LEN_W-1:0]  hdr_meta_flits_s;
  logic [IP_ADDR_W-1:0]  meta_src_ip_s;
  logic [IP_ADDR_W-1:0]  meta_dst_ip_s;
  logic [PORT_NUM_W-1:0] pay_src_port_s;
  logic [PORT_NUM_W-1:0] pay_dst_port_s;

  logic                  last_s;
  logic                  push_flit_s;
  logic                  meta_end_s;
  logic                  ok_s;
  logic                  xfer_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  q_full_s;
  ip_tuple_q_entry       push_entry_s;
  logic [ENTRY_W-1:0]    q_head_bits_s;
  ip_tuple_q_entry       q_head_s;

  // Field views of the current flit.
  assign hdr_msg_len_s    = src_data[DATA_W-1-HDR_MSG_LEN_OFF -: MSG_LEN_W];
  assign hdr_meta_flits_s = MSG_LEN_W'(src_data[DATA_W-1-HDR_META_FLITS_OFF -: META_FLITS_W]);
  assign meta_src_ip_s    = src_data[DATA_W-1-META_SRC_IP_OFF -: IP_ADDR_W];
  assign meta_dst_ip_s    = src_data[DATA_W-1-META_DST_IP_OFF -: IP_ADDR_W];
  assign pay_src_port_s   = src_data[PORT_SRC_MSB -: PORT_NUM_W];
  assign pay_dst_port_s   = src_data[PORT_DST_MSB -: PORT_NUM_W];

  // Handshake: the only back-pressure added is a push meeting a full queue.
  assign pop_s    = tuple_val & tuple_rdy;
  assign ok_s     = ~(push_flit_s & q_full_s & ~pop_s);
  assign src_rdy  = dst_rdy & ok_s;
  assign dst_val  = src_val & ok_s;
  assign dst_data = src_data;
  assign dst_last = last_s;
  assign xfer_s   = src_val & src_rdy;
  assign push_s   = xfer_s & push_flit_s;

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next parser state, advancing only on a flit transfer.
  always_comb begin
    state_d = state_q;
    if (xfer_s) begin
      case (state_q)
        HDR: begin
          if (last_s) begin
            state_d = HDR;
          end else if (hdr_meta_flits_s == MSG_LEN_ZERO) begin
            state_d = PAY;
          end else begin
            state_d = META;
          end
        end
        META: begin
          if (last_s) begin
            state_d = HDR;
          end else if (meta_end_s) begin
            state_d = PAY;
          end else begin
            state_d = META;
          end
        end
        PAY: begin
          if (last_s) begin
            state_d = HDR;
          end else begin
            state_d = BODY;
          end
        end
        BODY: begin
          if (last_s) begin
            state_d = HDR;
          end else begin
            state_d = BODY;
          end
        end
        default: state_d = HDR;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Per-state flags: last flit of the message and whether this flit pushes.
  // A metadata flit that ends the message pushes even if the header claimed
  // more metadata, so every message yields exactly one tuple.
  always_comb begin
    last_s      = 1'b0;
    push_flit_s = 1'b0;
    meta_end_s  = (meta_cnt_q == (meta_flits_q - MSG_LEN_ONE));
    case (state_q)
      HDR: begin
        last_s      = (hdr_msg_len_s == MSG_LEN_ONE);
        push_flit_s = last_s;
      end
      META: begin
        last_s      = (rem_q == MSG_LEN_ONE);
        push_flit_s = last_s;
      end
      PAY: begin
        last_s      = (rem_q == MSG_LEN_ONE);
        push_flit_s = 1'b1;
      end
      BODY: begin
        last_s      = (rem_q == MSG_LEN_ONE);
        push_flit_s = 1'b0;
      end
      default: begin
        last_s      = 1'b0;
        push_flit_s = 1'b0;
      end
    endcase
  end

  // Counters and staged IPs; the staged IPs restart at zero with each header.
  always_comb begin
    rem_d           = rem_q;
    meta_cnt_d      = meta_cnt_q;
    meta_flits_d    = meta_flits_q;
    staged_src_ip_d = staged_src_ip_q;
    staged_dst_ip_d = staged_dst_ip_q;
    if (xfer_s) begin
      case (state_q)
        HDR: begin
          rem_d           = hdr_msg_len_s - MSG_LEN_ONE;
          meta_cnt_d      = MSG_LEN_ZERO;
          meta_flits_d    = hdr_meta_flits_s;
          staged_src_ip_d = '0;
          staged_dst_ip_d = '0;
        end
        META: begin
          if (meta_cnt_q == IP_META_IDX_L) begin
            staged_src_ip_d = meta_src_ip_s;
            staged_dst_ip_d = meta_dst_ip_s;
          end else begin
            staged_src_ip_d = staged_src_ip_q;
            staged_dst_ip_d = staged_dst_ip_q;
          end
          meta_cnt_d = meta_cnt_q + MSG_LEN_ONE;
          rem_d      = rem_q - MSG_LEN_ONE;
        end
        PAY:     rem_d = rem_q - MSG_LEN_ONE;
        BODY:    rem_d = rem_q - MSG_LEN_ONE;
        default: rem_d = rem_q;
      endcase
    end else begin
      rem_d = rem_q;
    end
  end

  // Entry pushed this cycle. The next-value IPs are used so that a capture
  // and a push on the same metadata flit carry the fresh addresses, and a
  // header-only push carries zeros.
  always_comb begin
    if (state_q == PAY) begin
      push_entry_s = make_entry(staged_src_ip_d, staged_dst_ip_d,
                                pay_src_port_s, pay_dst_port_s, 1'b1);
    end else begin
      push_entry_s = make_entry(staged_src_ip_d, staged_dst_ip_d,
                                {PORT_NUM_W{1'b0}}, {PORT_NUM_W{1'b0}}, 1'b0);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q           <= '0;
      meta_cnt_q      <= '0;
      meta_flits_q    <= '0;
      staged_src_ip_q <= '0;
      staged_dst_ip_q <= '0;
    end else begin
      rem_q           <= rem_d;
      meta_cnt_q      <= meta_cnt_d;
      meta_flits_q    <= meta_flits_d;
      staged_src_ip_q <= staged_src_ip_d;
      staged_dst_ip_q <= staged_dst_ip_d;
    end
  end

  ip_tuple_parse_q_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (TUPLE_Q_DEPTH)
  ) u_tuple_q (
    .clk     (clk),
    .rst     (rst),
    .wr_val  (push_s),
    .wr_data (push_entry_s),
    .full    (q_full_s),
    .rd_val  (tuple_val),
    .rd_data (q_head_bits_s),
    .rd_rdy  (tuple_rdy),
    .occ     (tuple_q_occ)
  );

  assign q_head_s        = ip_tuple_q_entry'(q_head_bits_s);
  assign tuple           = q_head_s.tuple;
  assign tuple_has_ports = q_head_s.has_ports;

  ip_tuple_parse_q_chk #(
    .DEPTH (TUPLE_Q_DEPTH)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .hdr_xfer    (xfer_s & (state_q == HDR)),
    .hdr_msg_len (hdr_msg_len_s),
    .occ         (tuple_q_occ)
  );

endmodule

// File: tb/tb_ip_tuple_parse_q.sv
// Bench for ip_tuple_parse_q: directed table, queue-full sequence, offset
// variant, then randomized traffic against a message-level reference model.
module tb_ip_tuple_parse_q;
  import ip_tuple_parse_q_pkg::*;

  localparam int DW    = 256;
  localparam int DEPTH = 4;

  typedef logic [DW-1:0] flit_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  // Main instance (defaults).
  logic       src_val, src_rdy, dst_val, dst_last, dst_rdy;
  logic       tuple_val, tuple_has_ports, tuple_rdy;
  flit_t      src_data, dst_data;
  hash_struct tuple;
  logic [2:0] tuple_q_occ;
  // Offset/index variant.
  logic       b_src_val, b_src_rdy, b_dst_val, b_dst_last, b_dst_rdy;
  logic       b_tuple_val, b_tuple_has_ports, b_tuple_rdy;
  flit_t      b_src_data, b_dst_data;
  hash_struct b_tuple;
  logic [2:0] b_tuple_q_occ;

  ip_tuple_parse_q #(.DATA_W(DW), .PORT_OFFSET(0), .IP_META_IDX(0), .TUPLE_Q_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .src_val(src_val), .src_data(src_data), .src_rdy(src_rdy),
    .dst_val(dst_val), .dst_data(dst_data), .dst_last(dst_last), .dst_rdy(dst_rdy),
    .tuple_val(tuple_val), .tuple(tuple), .tuple_has_ports(tuple_has_ports),
    .tuple_rdy(tuple_rdy), .tuple_q_occ(tuple_q_occ));

  ip_tuple_parse_q #(.DATA_W(DW), .PORT_OFFSET(16), .IP_META_IDX(1), .TUPLE_Q_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .src_val(b_src_val), .src_data(b_src_data), .src_rdy(b_src_rdy),
    .dst_val(b_dst_val), .dst_data(b_dst_data), .dst_last(b_dst_last), .dst_rdy(b_dst_rdy),
    .tuple_val(b_tuple_val), .tuple(b_tuple), .tuple_has_ports(b_tuple_has_ports),
    .tuple_rdy(b_tuple_rdy), .tuple_q_occ(b_tuple_q_occ));

  int checks = 0;
  int errors = 0;

  flit_t fq[$];
  logic [96:0] mq[$];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic flit_t rand_flit();
    flit_t r;
    for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  // Build a message into fq: header, meta flits (IPs in flit ipidx), payload
  // (ports in the first payload flit at poff bits below the MSB).
  task automatic build_msg(input int len, input int meta, input int ipidx, input int poff,
                           input logic [31:0] sip, input logic [31:0] dip,
                           input logic [15:0] sp, input logic [15:0] dp);
    flit_t f;
    fq.delete();
    f = rand_flit();
    f[231:216] = len[15:0];
    f[183:176] = meta[7:0];
    fq.push_back(f);
    for (int k = 0; k < len - 1; k++) begin
      f = rand_flit();
      if (k < meta) begin
        if (k == ipidx) begin
          f[255:224] = sip;
          f[223:192] = dip;
        end
      end else if (k == meta) begin
        f[255-poff -: 16] = sp;
        f[239-poff -: 16] = dp;
      end
      fq.push_back(f);
    end
  endtask

  // Reference: the tuple a message must produce, as {tuple, has_ports}.
  function automatic logic [96:0] exp_tuple(input int len, input int meta, input int ipidx,
                                            input logic [31:0] sip, input logic [31:0] dip,
                                            input logic [15:0] sp, input logic [15:0] dp);
    logic [63:0] ips;
    if (len == 1) return 97'h0;
    ips = (ipidx < meta) ? {sip, dip} : 64'h0;
    if (meta < len - 1) return {ips, sp, dp, 1'b1};
    return {ips, 32'h0, 1'b0};
  endfunction

  // Reference: index of the flit that carries the push.
  function automatic int push_index(input int len, input int meta);
    if (len == 1) return 0;
    if (meta >= len - 1) return len - 1;
    return meta + 1;
  endfunction

  typedef struct {
    int          len;
    int          meta;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [96:0] exp;
  } vec_t;

  vec_t vt[5];
  flit_t bq[$];
  logic [96:0] bexp[6];

  initial begin
    int len, meta, p, cyc;
    logic [31:0] sip, dip;
    logic [15:0] sp, dp;
    logic [96:0] e;
    logic exp_pop, pf, ok;
    bit abort, did_reset;

    vt[0] = '{4, 1, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050,
              {32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050, 1'b1}};
    vt[1] = '{1, 0, 32'hDEADBEEF, 32'hCAFEF00D, 16'h1111, 16'h2222, 97'h0};
    vt[2] = '{2, 1, 32'hC0A80001, 32'hC0A80002, 16'h4444, 16'h5555,
              {32'hC0A80001, 32'hC0A80002, 16'h0000, 16'h0000, 1'b0}};
    vt[3] = '{3, 0, 32'h01020304, 32'h05060708, 16'hABCD, 16'hEF01,
              {32'h00000000, 32'h00000000, 16'hABCD, 16'hEF01, 1'b1}};
    vt[4] = '{5, 2, 32'hAC100001, 32'hAC100002, 16'h0100, 16'h0200,
              {32'hAC100001, 32'hAC100002, 16'h0100, 16'h0200, 1'b1}};

    rst = 1'b1;
    src_val = 1'b0; src_data = '0; dst_rdy = 1'b0; tuple_rdy = 1'b0;
    b_src_val = 1'b0; b_src_data = '0; b_dst_rdy = 1'b0; b_tuple_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tuple_val", tuple_val, 1'b0);
    check("reset_occ", tuple_q_occ, 3'd0);
    check("reset_dst_val", dst_val, 1'b0);

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      build_msg(vt[v].len, vt[v].meta, 0, 0, vt[v].sip, vt[v].dip, vt[v].sp, vt[v].dp);
      for (int i = 0; i < vt[v].len; i++) begin
        @(posedge clk); #1;
        src_val = 1'b1; src_data = fq[i]; dst_rdy = 1'b1; tuple_rdy = 1'b0;
        @(negedge clk);
        check("dir_dst_val", dst_val, 1'b1);
        check("dir_src_rdy", src_rdy, 1'b1);
        check("dir_dst_last", dst_last, (i == vt[v].len - 1));
      end
      @(posedge clk); #1 src_val = 1'b0;
      @(negedge clk);
      check("dir_occ_one", tuple_q_occ, 3'd1);
      check("dir_tuple", {tuple, tuple_has_ports}, vt[v].exp);
      @(posedge clk); #1 tuple_rdy = 1'b1;
      @(posedge clk); #1 tuple_rdy = 1'b0;
      @(negedge clk);
      check("dir_occ_drained", tuple_q_occ, 3'd0);
    end

    // Five 3-flit messages with the consumer stalled.
    bq.delete();
    for (int k = 1; k <= 5; k++) begin
      build_msg(3, 1, 0, 0, 32'h0B000000 + k, 32'h0C000000 + k, 16'h1000 + k[15:0], 16'h2000 + k[15:0]);
      bexp[k] = {32'h0B000000 + k, 32'h0C000000 + k, 16'h1000 + k[15:0], 16'h2000 + k[15:0], 1'b1};
      foreach (fq[j]) bq.push_back(fq[j]);
    end
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      src_val = 1'b1; src_data = bq[i]; dst_rdy = 1'b1; tuple_rdy = 1'b0;
      @(negedge clk);
      check("full_pre_src_rdy", src_rdy, 1'b1);
    end
    @(posedge clk); #1 src_data = bq[14];
    @(negedge clk);
    check("full_stall_src_rdy", src_rdy, 1'b0);
    check("full_stall_dst_val", dst_val, 1'b0);
    check("full_stall_occ", tuple_q_occ, 3'd4);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_stall2_src_rdy", src_rdy, 1'b0);
    @(posedge clk); #1 tuple_rdy = 1'b1;
    @(negedge clk);
    check("full_release_src_rdy", src_rdy, 1'b1);
    check("full_release_dst_val", dst_val, 1'b1);
    check("full_release_last", dst_last, 1'b1);
    check("full_head_1", {tuple, tuple_has_ports}, bexp[1]);
    @(posedge clk); #1 src_val = 1'b0; tuple_rdy = 1'b0;
    @(negedge clk);
    check("full_pushpop_occ", tuple_q_occ, 3'd4);
    @(posedge clk); #1 tuple_rdy = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("full_order", {tuple, tuple_has_ports}, bexp[k]);
      @(posedge clk); #1;
    end
    tuple_rdy = 1'b0;
    @(negedge clk);
    check("full_empty_occ", tuple_q_occ, 3'd0);
    check("full_empty_val", tuple_val, 1'b0);

    // Port offset 16, IPs from the second metadata flit.
    build_msg(4, 2, 1, 16, 32'h11223344, 32'h55667788, 16'h9ABC, 16'hDEF0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      b_src_val = 1'b1; b_src_data = fq[i]; b_dst_rdy = 1'b1;
      @(negedge clk);
      check("off_dst_last", b_dst_last, (i == 3));
    end
    @(posedge clk); #1 b_src_val = 1'b0;
    @(negedge clk);
    check("off_occ", b_tuple_q_occ, 3'd1);
    check("off_tuple", {b_tuple, b_tuple_has_ports},
          {32'h11223344, 32'h55667788, 16'h9ABC, 16'hDEF0, 1'b1});

    // Random traffic against the message-level model.
    mq.delete();
    abort = 1'b0;
    did_reset = 1'b0;
    for (int m = 0; m < 1000 && !abort; m++) begin
      len  = $urandom_range(1, 8);
      meta = (len == 1) ? 0 : $urandom_range(0, len - 1);
      if (m == 500) begin
        len = 6; meta = 1;
      end
      sip = $urandom(); dip = $urandom();
      sp = 16'($urandom()); dp = 16'($urandom());
      build_msg(len, meta, 0, 0, sip, dip, sp, dp);
      e = exp_tuple(len, meta, 0, sip, dip, sp, dp);
      p = push_index(len, meta);
      cyc = 0;
      for (int i = 0; i < len; ) begin
        @(posedge clk); #1;
        if (m == 500 && i == 3 && !did_reset) begin
          did_reset = 1'b1;
          rst = 1'b1; src_val = 1'b0; dst_rdy = 1'b0; tuple_rdy = 1'b0;
          @(posedge clk); #1 rst = 1'b0;
          @(negedge clk);
          check("midrst_tuple_val", tuple_val, 1'b0);
          check("midrst_occ", tuple_q_occ, 3'd0);
          check("midrst_dst_val", dst_val, 1'b0);
          mq.delete();
          break;
        end
        src_val   = ($urandom_range(0, 3) != 0);
        src_data  = src_val ? fq[i] : rand_flit();
        dst_rdy   = ($urandom_range(0, 3) != 0);
        tuple_rdy = ($urandom_range(0, 2) == 0);
        @(negedge clk);
        exp_pop = tuple_rdy && (mq.size() > 0);
        check("rnd_tuple_val", tuple_val, (mq.size() > 0));
        check("rnd_occ", tuple_q_occ, mq.size());
        if (mq.size() > 0) check("rnd_tuple", {tuple, tuple_has_ports}, mq[0]);
        pf = (i == p);
        ok = !(pf && mq.size() == DEPTH && !exp_pop);
        if (src_val) begin
          check("rnd_src_rdy", src_rdy, dst_rdy && ok);
          check("rnd_dst_val", dst_val, ok);
          if (ok) begin
            check("rnd_dst_data", dst_data, fq[i]);
            check("rnd_dst_last", dst_last, (i == len - 1));
          end
        end else begin
          check("rnd_dst_val_idle", dst_val, 1'b0);
        end
        if (exp_pop) void'(mq.pop_front());
        if (src_val && dst_rdy && ok) begin
          if (pf) mq.push_back(e);
          i++;
        end
        cyc++;
        if (cyc > 400) begin
          checks++; errors++;
          $display("FAIL rnd_watchdog: message %0d stuck at flit %0d of %0d", m, i, len);
          abort = 1'b1;
          break;
        end
      end
    end

    // Drain what is left.
    @(posedge clk); #1 src_val = 1'b0; tuple_rdy = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      @(negedge clk);
      if (mq.size() > 0) begin
        check("drain_tuple", {tuple, tuple_has_ports}, mq[0]);
        void'(mq.pop_front());
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("drain_occ", tuple_q_occ, 3'd0);
    check("drain_val", tuple_val, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
